// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: buffers bus writes and launches one
// frame at a time, waiting for the transmitter's tx_end before the next launch.
module uart_tx_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              ovf_clr,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    input  logic              tx_end,
    output logic              dbg_state_o
);

    // Handshake: a write is taken on any edge where wr_en=1 and full=0
    // (full acts as not-ready, and a write against full is dropped and flagged);
    // a launch happens on an edge where the FSM is IDLE, empty=0 and tx_busy=0,
    // and the transmitter hands back control with a one-cycle tx_end.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              launch;
    logic              wr_acc;
    logic              wr_drop;
    logic [7:0]        mem_q [DEPTH];

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_q && !tx_busy) begin
                    launch  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (tx_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A dropped write stays dropped even when a pop frees a slot this cycle.
    always_comb begin
        wr_acc     = wr_en && !full_q;
        wr_drop    = wr_en && full_q;
        wr_ptr_d   = wr_ptr_q + ADDR_W'(wr_acc);
        rd_ptr_d   = rd_ptr_q + ADDR_W'(launch);
        count_d    = count_q + {{ADDR_W{1'b0}}, wr_acc} - {{ADDR_W{1'b0}}, launch};
        full_d     = (count_d == FULL_CNT);
        empty_d    = (count_d == '0);
        ovf_d      = wr_drop | (ovf_q & ~ovf_clr);
        tx_start_d = launch;
        tx_data_d  = launch ? mem_q[rd_ptr_q] : tx_data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ovf_q      <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            ovf_q      <= ovf_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign full        = full_q;
    assign empty       = empty_q;
    assign count       = count_q;
    assign overflow    = ovf_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx_fifo;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic            clk;
    logic            reset;
    logic            wr_en;
    logic [7:0]      wr_data;
    logic            ovf_clr;
    logic            full;
    logic            empty;
    logic [ADDR_W:0] count;
    logic            overflow;
    logic            tx_start;
    logic [7:0]      tx_data;
    logic            tx_busy;
    logic            tx_end;
    logic            dbg_state_o;

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .ovf_clr    (ovf_clr),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .tx_end     (tx_end),
        .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // ---------------- transmitter model ----------------
    logic hold_busy;
    logic frame_busy;
    logic spur_en;
    int   frame_len;
    int   rem;

    assign tx_busy = frame_busy | hold_busy;

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            rem        = 0;
            frame_busy = 1'b0;
            tx_end     = 1'b0;
        end else begin
            tx_end = 1'b0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) tx_end = 1'b1;
            end else begin
                frame_busy = 1'b0;
            end
            if (tx_start) begin
                frame_busy = 1'b1;
                rem        = frame_len;
            end else if (!frame_busy && spur_en && $urandom_range(0, 7) == 0) begin
                tx_end = 1'b1;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] exp_q[$];
    logic       m_send;
    logic       m_start;
    logic [7:0] m_data;
    logic       m_ovf;
    logic       m_launch;
    logic       m_drop;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            m_send  = 1'b0;
            m_start = 1'b0;
            m_data  = 8'h00;
            m_ovf   = 1'b0;
        end else begin
            m_launch = !m_send && exp_q.size() != 0 && !tx_busy;
            m_drop   = wr_en && exp_q.size() == DEPTH;
            m_start  = m_launch;
            if (m_launch) m_data = exp_q.pop_front();
            if (wr_en && !m_drop) exp_q.push_back(wr_data);
            if (m_launch) m_send = 1'b1;
            else if (tx_end) m_send = 1'b0;
            if (m_drop) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
        end
    end

    // ---------------- scoreboard / compare ----------------
    logic [7:0] launched[$];
    int         n_starts      = 0;
    int         edge_n        = 0;
    int         last_end_edge = 0;
    bit         have_end      = 0;
    bit         gap_chk       = 0;

    always @(posedge clk) begin
        #1;
        edge_n++;
        if (reset) begin
            chk("count",    32'(count),       32'(exp_q.size()));
            chk("full",     32'(full),        32'(exp_q.size() == DEPTH));
            chk("empty",    32'(empty),       32'(exp_q.size() == 0));
            chk("overflow", 32'(overflow),    32'(m_ovf));
            chk("tx_start", 32'(tx_start),    32'(m_start));
            chk("tx_data",  32'(tx_data),     32'(m_data));
            chk("state",    32'(dbg_state_o), 32'(m_send));
            if (tx_start) begin
                launched.push_back(tx_data);
                n_starts++;
                if (gap_chk && have_end) chk("b2b_gap", 32'(edge_n - last_end_edge), 32'd1);
            end
            if (tx_end) begin
                last_end_edge = edge_n;
                have_end      = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = b;
    endtask

    task automatic idle_bus();
        @(negedge clk);
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int k = 0;
        while ((dbg_state_o !== 1'b0 || tx_busy !== 1'b0 || count !== '0) && k < budget) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (k >= budget) begin
            total++;
            bad++;
            $display("FAIL %s: still busy after %0d cycles, want idle", nm, budget);
        end
    endtask

    // ---------------- stimulus ----------------
    int starts_before;

    initial begin
        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        ovf_clr   = 1'b0;
        hold_busy = 1'b0;
        spur_en   = 1'b0;
        frame_len = 10;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count",    32'(count),       32'd0);
        chk("rst_empty",    32'(empty),       32'd1);
        chk("rst_full",     32'(full),        32'd0);
        chk("rst_overflow", 32'(overflow),    32'd0);
        chk("rst_tx_start", 32'(tx_start),    32'd0);
        chk("rst_tx_data",  32'(tx_data),     32'h00);
        chk("rst_state",    32'(dbg_state_o), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // single byte
        write_byte(8'hA5);
        idle_bus();
        @(posedge clk);
        #1;
        chk("single_start", 32'(tx_start),    32'd1);
        chk("single_data",  32'(tx_data),     32'hA5);
        chk("single_empty", 32'(empty),       32'd1);
        chk("single_state", 32'(dbg_state_o), 32'd1);
        wait_idle("single_idle", 60);
        chk("single_nlaunch", 32'(launched.size()), 32'd1);
        launched.delete();

        // burst of eight back-to-back frames
        have_end = 1'b0;
        gap_chk  = 1'b1;
        for (int i = 1; i <= 8; i++) write_byte(8'(i));
        idle_bus();
        wait_idle("burst_idle", 300);
        gap_chk = 1'b0;
        chk("burst_nlaunch", 32'(launched.size()), 32'd8);
        for (int i = 0; i < 8 && i < launched.size(); i++)
            chk("burst_order", 32'(launched[i]), 32'(i + 1));
        launched.delete();

        // overflow
        hold_busy = 1'b1;
        for (int i = 0; i < 9; i++) write_byte(8'h10 + 8'(i));
        idle_bus();
        chk("ovf_count", 32'(count),    32'd8);
        chk("ovf_full",  32'(full),     32'd1);
        chk("ovf_flag",  32'(overflow), 32'd1);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);
        @(negedge clk);
        ovf_clr = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h99;
        idle_bus();
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        chk("ovf_count2",   32'(count),    32'd8);
        hold_busy = 1'b0;
        wait_idle("ovf_drain", 300);
        chk("ovf_nlaunch", 32'(launched.size()), 32'd8);
        for (int i = 0; i < 8 && i < launched.size(); i++)
            chk("ovf_order", 32'(launched[i]), 32'h10 + 32'(i));
        launched.delete();

        // reset in the middle of a frame
        hold_busy = 1'b1;
        for (int i = 0; i < 4; i++) write_byte(8'h21 + 8'(i));
        idle_bus();
        hold_busy = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_state", 32'(dbg_state_o), 32'd1);
        chk("mid_count", 32'(count),       32'd3);
        reset = 1'b0;
        #1;
        chk("mid_rst_count",    32'(count),       32'd0);
        chk("mid_rst_empty",    32'(empty),       32'd1);
        chk("mid_rst_full",     32'(full),        32'd0);
        chk("mid_rst_tx_start", 32'(tx_start),    32'd0);
        chk("mid_rst_tx_data",  32'(tx_data),     32'h00);
        chk("mid_rst_state",    32'(dbg_state_o), 32'd0);
        starts_before = n_starts;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_nostart", 32'(n_starts), 32'(starts_before));
        chk("post_rst_empty",   32'(empty),    32'd1);
        write_byte(8'h5A);
        idle_bus();
        wait_idle("post_rst_idle", 60);
        chk("post_rst_data", 32'(launched[$]), 32'h5A);
        launched.delete();

        // busy gate
        hold_busy = 1'b1;
        starts_before = n_starts;
        write_byte(8'h77);
        idle_bus();
        repeat (5) @(negedge clk);
        chk("gate_nostart", 32'(n_starts), 32'(starts_before));
        chk("gate_empty",   32'(empty),    32'd0);
        hold_busy = 1'b0;
        wait_idle("gate_idle", 60);
        chk("gate_data", 32'(launched[$]), 32'h77);
        launched.delete();

        // randomized traffic: short frames, stray tx_end, busy holds, clears
        spur_en = 1'b1;
        repeat (800) begin
            @(negedge clk);
            wr_en     = 1'($urandom_range(0, 1));
            wr_data   = 8'($urandom);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            frame_len = $urandom_range(1, 4);
            if ($urandom_range(0, 31) == 0) hold_busy = ~hold_busy;
        end
        idle_bus();
        hold_busy = 1'b0;
        spur_en   = 1'b0;
        wait_idle("rand_drain", 500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: simulation did not complete, want completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 8, number of byte entries (power of two).
REQ-002 Parameter ADDR_W, default 3, pointer width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 wr_en  input  1  bus write strobe; one byte per cycle while high.
REQ-006 wr_data  input  8  byte to enqueue.
REQ-007 ovf_clr  input  1  clears the sticky overflow flag.
REQ-008 full  output  1  registered; high when count == DEPTH.
REQ-009 empty  output  1  registered; high when count == 0.
REQ-010 count  output  ADDR_W+1  number of queued bytes, 0..DEPTH.
REQ-011 overflow  output  1  sticky; set when a write is dropped.
REQ-012 tx_start  output  1  one-cycle launch pulse to the downstream transmitter.
REQ-013 tx_data  output  8  byte for the transmitter; registered, stable from launch until the next launch.
REQ-014 tx_busy  input  1  transmitter is shifting a frame.
REQ-015 tx_end  input  1  one-cycle pulse marking the end of a frame's stop bit.

Function
REQ-016 Storage SHALL be a DEPTH x 8 circular buffer with ADDR_W-bit read and write pointers that wrap from DEPTH-1 to 0.
REQ-017 A write SHALL be accepted when wr_en=1 and full=0: mem[wr_ptr]<=wr_data, wr_ptr+1.
REQ-018 A write SHALL be dropped when wr_en=1 and full=1, even if a pop occurs in the same cycle; overflow is set on the next edge.
REQ-019 If ovf_clr=1 and an overflow event occur in the same cycle, overflow SHALL end up set (set wins).
REQ-020 FSM states: IDLE, SEND.
REQ-021 IDLE: when empty=0 and tx_busy=0, in one edge SHALL load tx_data<=mem[rd_ptr], pulse tx_start=1, advance rd_ptr (pop), and go to SEND.
REQ-022 In IDLE with empty=1 or tx_busy=1, tx_start SHALL stay 0 and the FSM SHALL stay in IDLE.
REQ-023 SEND: tx_start SHALL return to 0 after exactly one cycle; the FSM SHALL stay in SEND until tx_end=1, then return to IDLE.
REQ-024 tx_end received in IDLE SHALL be ignored.
REQ-025 Back-to-back frames: a byte queued during SEND SHALL be launched on the first IDLE cycle after tx_end, giving one cycle of gap between tx_end and the next tx_start.
REQ-026 Accepted write and pop in the same cycle SHALL leave count unchanged and move both pointers.
REQ-027 Writing to an empty FIFO SHALL not launch earlier than the cycle after the write (empty is registered).
REQ-028 count, full and empty SHALL be updated together on each edge and stay mutually consistent.

Reset
REQ-029 While reset=0: state=IDLE, pointers=0, count=0, empty=1, full=0, overflow=0, tx_start=0, tx_data=8'h00; memory contents are not reset.
REQ-030 A reset asserted in SEND SHALL abort the frame bookkeeping; after release the FSM is in IDLE with the FIFO empty.

Verification
REQ-031 Single byte: write 8'hA5 with tx_busy=0 -> tx_start pulse one cycle later, tx_data=8'hA5, empty=1, state SEND; tx_end pulse -> IDLE.
REQ-032 Burst: write 8'h01..8'h08 in 8 consecutive cycles, transmitter modelled 10 cycles/frame -> eight tx_start pulses in order 01..08, one per tx_end, with a 1-cycle gap after each tx_end.
REQ-033 Overflow: hold tx_busy=1, write 9 bytes -> count=8, full=1, 9th byte dropped, overflow=1; ovf_clr -> overflow=0; a simultaneous ovf_clr and dropped write -> overflow=1.
REQ-034 Wrap and concurrency: cycle 12+ bytes through the FIFO with writes coinciding with pops -> count constant on those cycles, data order preserved across pointer wrap.
REQ-035 Reset mid-frame: assert reset during SEND with count=3 -> all outputs at reset values immediately; after release no tx_start until a new write.
REQ-036 Busy gate: empty=0, tx_busy=1 in IDLE -> no tx_start until tx_busy=0.
